ctrl_seq: RTL

//   SAP-1 control sequencer. A 6-state ring counter (T1..T6) plus an opcode decoder.
//   It drives the active-high load/enable/ALU control word for pc, mar, ram, ir, A, B,
//   the ALU and the output register, sequencing fetch (T1-T3) and execute (T4-T6).

---
 rtl/ctrl_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - SAP-1 control sequencer: one-hot T1..T6 ring plus opcode decode
module ctrl_seq #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic [5:0] t_state,
    output logic       halted
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    state_t state, state_next;
    logic   halted_q, halted_next;

    // Falling-edge update keeps the control word settled across the datapath's rising edge.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= T1;
            halted_q <= 1'b0;
        end else begin
            state    <= state_next;
            halted_q <= halted_next;
        end
    end

    always_comb begin
        state_next  = state;
        halted_next = halted_q;
        cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0;
        li = 1'b0; ei = 1'b0; la = 1'b0; ea = 1'b0;
        su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;

        if (!$onehot(state)) begin
            state_next = T1;
        end else if (run && !halted_q) begin
            case (state)
                T1: begin
                    state_next = T2;
                    ep = 1'b1; lm = 1'b1;
                end
                T2: begin
                    state_next = T3;
                    cp = 1'b1;
                end
                T3: begin
                    state_next = T4;
                    ce = 1'b1; li = 1'b1;
                end
                T4: begin
                    state_next = T5;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ei = 1'b1; lm = 1'b1;
                        end
                        OP_OUT: begin
                            ea = 1'b1; lo = 1'b1;
                        end
                        OP_HLT: halted_next = 1'b1;
                        default: ;
                    endcase
                end
                T5: begin
                    state_next = T6;
                    case (opcode)
                        OP_LDA: begin
                            ce = 1'b1; la = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ce = 1'b1; lb = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    state_next = T1;
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        eu = 1'b1; la = 1'b1;
                        su = (opcode == OP_SUB);
                    end
                end
                default: state_next = T1;
            endcase
        end
    end

    assign t_state = state;
    assign halted  = halted_q;

endmodule
